tsu_arb_queue: RTL

- Parametrised multi-channel timestamp capture and queue block; successor to the fixed two-queue (rx/tx) timestamp arrangement.
- Accepts capture strobes from NUM_CH sources, already synchronised to clk, and stamps each one with the current RTC time.
- Merges the captures through a round-robin arbiter into a single shared FIFO, which the register bank reads through one port.
- Adds features the two-queue arrangement lacks: a channel ID on every entry, per-channel overflow flags, and a synchronous flush.

---
 rtl/tsu_arb_queue.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/tsu_arb_queue.sv
// Multi-channel timestamp capture: per-channel hold/pend registers, round-robin merge into one shared FWFT FIFO.
// Optional macro TSU_ARB_QUEUE_DROP_CNT_EN adds per-channel 8-bit saturating drop counters (q_drop_cnt).

module tsu_arb_queue_ch #(
  parameter int TS_W  = 32,
  parameter int TAG_W = 24,
  parameter int CH_ID = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    cap_vld_i,
  input  logic [TAG_W-1:0]        cap_tag_i,
  input  logic [TS_W-1:0]         rtc_time_i,
  input  logic                    gnt_i,
  output logic                    pend_o,
  output logic [4+TAG_W+TS_W-1:0] hold_o,
`ifdef TSU_ARB_QUEUE_DROP_CNT_EN
  output logic [7:0]              drop_cnt_o,
`endif
  output logic                    ovf_o
);
  localparam int EW = 4 + TAG_W + TS_W;

  logic          pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] hold_q, hold_d;
  logic          accept, drop;

  // A grant in the same cycle frees the slot, so a new capture may land on it.
  always_comb begin
    accept = cap_vld_i & (~pend_q | gnt_i);
    drop   = cap_vld_i & pend_q & ~gnt_i;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    hold_d = hold_q;
    if (clr_i) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      pend_d = accept | (pend_q & ~gnt_i);
      ovf_d  = ovf_q | drop;
      if (accept) hold_d = {4'(CH_ID), cap_tag_i, rtc_time_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      hold_q <= hold_d;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;
  assign hold_o = hold_q;

`ifdef TSU_ARB_QUEUE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_i)                            drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif
endmodule

module tsu_arb_queue #(
  parameter int NUM_CH     = 2,
  parameter int TS_W       = 32,
  parameter int TAG_W      = 24,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TS_W-1:0]         rtc_time_in,
  input  logic [NUM_CH-1:0]       cap_vld,
  input  logic [NUM_CH*TAG_W-1:0] cap_tag,
  input  logic                    q_clr,
  input  logic                    q_rd_en,
  output logic                    q_rd_vld,
  output logic [4+TAG_W+TS_W-1:0] q_rd_data,
  output logic [DEPTH_LOG2:0]     q_rd_cnt,
`ifdef TSU_ARB_QUEUE_DROP_CNT_EN
  output logic [NUM_CH*8-1:0]     q_drop_cnt,
`endif
  output logic [NUM_CH-1:0]       q_ovf
);
  localparam int EW    = 4 + TAG_W + TS_W;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]         pend, gnt;
  logic [NUM_CH-1:0][EW-1:0] hold;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tsu_arb_queue_ch #(
      .TS_W  (TS_W),
      .TAG_W (TAG_W),
      .CH_ID (g)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (q_clr),
      .cap_vld_i  (cap_vld[g]),
      .cap_tag_i  (cap_tag[g*TAG_W +: TAG_W]),
      .rtc_time_i (rtc_time_in),
      .gnt_i      (gnt[g]),
      .pend_o     (pend[g]),
      .hold_o     (hold[g]),
`ifdef TSU_ARB_QUEUE_DROP_CNT_EN
      .drop_cnt_o (q_drop_cnt[g*8 +: 8]),
`endif
      .ovf_o      (q_ovf[g])
    );
  end

  // ---------------- arbiter ----------------
  logic [PW-1:0]         rr_q, rr_d;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_any, gnt_ok;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      int idx;
      idx = int'(rr_q) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_any && pend[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  // Full is judged on the registered count: a pop this cycle does not open a slot.
  assign gnt_ok = gnt_any & ~cnt_q[DEPTH_LOG2] & ~q_clr;

  always_comb begin
    gnt = '0;
    if (gnt_ok) gnt[gnt_idx] = 1'b1;
    rr_d = rr_q;
    if (q_clr)       rr_d = '0;
    else if (gnt_ok) rr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
  end

  // ---------------- shared FIFO ----------------
  logic [EW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [EW-1:0]         data_q, data_d, wr_data;
  logic                  pop, remain_nz;

  assign wr_data = hold[gnt_idx];
  assign pop     = q_rd_en & (cnt_q != '0) & ~q_clr;
  assign rd_nxt  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_comb begin
    remain_nz = pop ? (cnt_q > (DEPTH_LOG2+1)'(1)) : (cnt_q != '0);
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    data_d    = data_q;
    if (q_clr) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      rd_ptr_d = rd_nxt;
      if (gnt_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({gnt_ok, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      // Head register: next stored entry, or the incoming word when the FIFO drains to it.
      if (remain_nz)   data_d = mem[rd_nxt];
      else if (gnt_ok) data_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_ok) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q     <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
    end else begin
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
    end
  end

  assign q_rd_vld  = (cnt_q != '0);
  assign q_rd_data = data_q;
  assign q_rd_cnt  = cnt_q;
endmodule
